// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Holds the 4-bit op encoding, default latencies and the result bundle
// returned by the combinational arithmetic block.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div_zero;
    } calc_res_t;

endpackage

// File: rtl/e_mdu_if.sv
// E-stage <-> MDU bundle.
//   start/mdu_op/flush/src_a/src_b : request from the E-stage decoder
//   busy                           : multi-cycle op in flight (hazard unit)
//   hi/lo                          : architectural HI/LO for MFHI/MFLO
interface e_mdu_if;
    logic        start;
    logic [3:0]  mdu_op;
    logic        flush;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, mdu_op, flush, src_a, src_b,
                    input  busy, hi, lo);
    modport slave  (input  start, mdu_op, flush, src_a, src_b,
                    output busy, hi, lo);
endinterface

// File: rtl/e_mdu_calc.sv
// Combinational MDU arithmetic.
//   i_op  : op code (only MULT/MULTU/DIV/DIVU produce a result)
//   i_a   : multiplicand / dividend
//   i_b   : multiplier / divisor
//   o_res : {hi, lo, div_zero}; div: lo=quotient, hi=remainder
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output calc_res_t   o_res
);

    logic        w_sgn;
    logic [63:0] w_prod;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic        w_bz;

    always_comb begin
        w_sgn  = (i_op == OP_MULT) || (i_op == OP_DIV);
        w_bz   = (i_b == 32'd0);
        w_prod = w_sgn ? ({{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b})
                       : ({32'd0, i_a} * {32'd0, i_b});
        // Signed divide runs on magnitudes; -0x80000000 wraps to itself,
        // which is exactly the magnitude needed, so no overflow special case.
        w_ua   = (w_sgn && i_a[31]) ? -i_a : i_a;
        w_ub   = (w_sgn && i_b[31]) ? -i_b : i_b;
        w_q    = w_bz ? 32'd0 : (w_ua / w_ub);
        w_r    = w_bz ? 32'd0 : (w_ua % w_ub);

        o_res  = '0;
        case (i_op)
            OP_MULT, OP_MULTU: begin
                o_res.hi = w_prod[63:32];
                o_res.lo = w_prod[31:0];
            end
            OP_DIV, OP_DIVU: begin
                // Truncate toward zero; remainder follows the dividend's sign.
                o_res.lo       = (w_sgn && (i_a[31] ^ i_b[31])) ? -w_q : w_q;
                o_res.hi       = (w_sgn && i_a[31]) ? -w_r : w_r;
                o_res.div_zero = w_bz;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit with fixed multi-cycle latency.
//   clk : rising-edge clock
//   res : asynchronous active-low reset
//   bus : e_mdu_if.slave (start/mdu_op/flush/src_a/src_b in; busy/hi/lo out)
// The result is computed at accept time and parked in pend_hi/pend_lo; the
// counter only models latency. HI/LO commit on the edge where counter==1.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic   clk,
    input  logic   res,
    e_mdu_if.slave bus
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e      r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;
    logic [31:0] r_pend_hi, w_pend_hi_nxt;
    logic [31:0] r_pend_lo, w_pend_lo_nxt;
    logic        r_pend_dz, w_pend_dz_nxt;
    logic        w_accept;
    logic        w_busy;
    calc_res_t   w_calc;

    e_mdu_calc u_calc (
        .i_op  (bus.mdu_op),
        .i_a   (bus.src_a),
        .i_b   (bus.src_b),
        .o_res (w_calc)
    );

    // State register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_dz <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_dz <= w_pend_dz_nxt;
        end
    end

    // Next-state logic. Requests arriving while busy are dropped outright;
    // flush only cancels the instruction currently in E, never one in flight.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_dz_nxt = r_pend_dz;
        w_accept      = bus.start & ~bus.flush & (r_state == S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (bus.mdu_op)
                        OP_MULT, OP_MULTU: begin
                            w_state_nxt   = S_BUSY;
                            w_cnt_nxt     = CW'(MULT_CYCLES);
                            w_pend_hi_nxt = w_calc.hi;
                            w_pend_lo_nxt = w_calc.lo;
                            w_pend_dz_nxt = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_state_nxt   = S_BUSY;
                            w_cnt_nxt     = CW'(DIV_CYCLES);
                            w_pend_hi_nxt = w_calc.hi;
                            w_pend_lo_nxt = w_calc.lo;
                            w_pend_dz_nxt = w_calc.div_zero;
                        end
                        OP_MTHI: w_hi_nxt = bus.src_a;
                        OP_MTLO: w_lo_nxt = bus.src_a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (r_cnt > CW'(1)) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    // Divide-by-zero burns the full latency but leaves HI/LO.
                    if (!r_pend_dz) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: all derived from registers only.
    always_comb begin
        w_busy = (r_state == S_BUSY);
    end

    assign bus.busy = w_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    e_mdu_if bus ();

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h required=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        bus.start  = 1'b1;
        bus.mdu_op = op;
        bus.src_a  = a;
        bus.src_b  = b;
        bus.flush  = fl;
        step();
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.mdu_op = OP_NONE;
    endtask

    task automatic push(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                        input int cyc);
        exp_t e;
        e.hi = hi; e.lo = lo; e.cyc = cyc; e.tag = tag;
        sb.push_back(e);
    endtask

    // Counts busy-high cycles (k already elapsed since accept), then pops
    // the scoreboard and compares busy length and committed HI/LO.
    task automatic wait_done(input int k);
        exp_t e;
        int   n;
        n = k;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_empty: observed=0 entries required>=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_busy_cycles"}, 32'(n), 32'(e.cyc));
            chk({e.tag, "_hi"}, bus.hi, e.hi);
            chk({e.tag, "_lo"}, bus.lo, e.lo);
        end
    endtask

    // Single-cycle ops: pop immediately and compare with busy low.
    task automatic check_now();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_empty: observed=0 entries required>=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
            chk({e.tag, "_hi"}, bus.hi, e.hi);
            chk({e.tag, "_lo"}, bus.lo, e.lo);
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.mdu_op = OP_NONE;
        bus.flush  = 1'b0;
        bus.src_a  = '0;
        bus.src_b  = '0;

        // Reset state
        #12;
        push("reset", 32'h0, 32'h0, 0);
        check_now();
        step();
        res = 1'b1;
        step();

        // Reset mid-divide: async clear must hit HI and busy immediately
        drive(OP_MTHI, 32'h55, 32'h0, 1'b0);
        push("mthi55", 32'h55, 32'h0, 0);
        check_now();
        drive(OP_DIV, 32'd100, 32'd7, 1'b0);
        step();
        step();
        #2;
        res = 1'b0;
        #1;
        push("async_rst", 32'h0, 32'h0, 0);
        check_now();
        step();
        res = 1'b1;
        repeat (12) step();
        push("post_rst", 32'h0, 32'h0, 0);
        check_now();

        // MULT signed, checking HI is untouched mid-count
        drive(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        chk("mult_hi_midcount", bus.hi, 32'h0);
        wait_done(0);

        // MULTU same operands
        drive(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        push("multu", 32'h0000_0002, 32'hFFFF_FFFA, 5);
        wait_done(0);

        // DIV -7/2
        drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        push("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        wait_done(0);

        // DIVU 7/2
        drive(OP_DIVU, 32'd7, 32'd2, 1'b0);
        push("divu", 32'd1, 32'd3, 10);
        wait_done(0);

        // Signed overflow corner
        drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        push("div_ovf", 32'h0, 32'h8000_0000, 10);
        wait_done(0);

        // MTHI then MTLO on consecutive edges
        drive(OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b0);
        push("mthi", 32'hDEAD_BEEF, 32'h8000_0000, 0);
        check_now();
        drive(OP_MTLO, 32'h1234, 32'h0, 1'b0);
        push("mtlo", 32'hDEAD_BEEF, 32'h1234, 0);
        check_now();

        // start+flush suppresses MTHI
        drive(OP_MTHI, 32'h5, 32'h0, 1'b1);
        push("mthi_flush", 32'hDEAD_BEEF, 32'h1234, 0);
        check_now();

        // NONE and undefined codes do nothing
        drive(OP_NONE, 32'h77, 32'h1, 1'b0);
        drive(4'hF, 32'h77, 32'h1, 1'b0);
        push("undef_op", 32'hDEAD_BEEF, 32'h1234, 0);
        check_now();

        // Divide by zero keeps HI/LO
        drive(OP_MTHI, 32'h11, 32'h0, 1'b0);
        drive(OP_MTLO, 32'h22, 32'h0, 1'b0);
        drive(OP_DIVU, 32'd99, 32'd0, 1'b0);
        push("div0", 32'h11, 32'h22, 10);
        wait_done(0);

        // MULT while busy is dropped; flush during busy has no effect
        drive(OP_DIVU, 32'd100, 32'd7, 1'b0);
        push("div_busy", 32'd2, 32'd14, 10);
        step();
        drive(OP_MULT, 32'd9, 32'd9, 1'b0);
        drive(OP_MULT, 32'd9, 32'd9, 1'b1);
        wait_done(3);
        repeat (8) step();
        push("no_late_mult", 32'd2, 32'd14, 0);
        check_now();

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
